// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I control sequencer: decodes the state register, ir and handshake
// inputs into datapath controls, with memory timeout, illegal-opcode trap, halt and instret.
module rv_mc_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             busy,
    output logic [3:0]       state,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | instruction read, waits for mem_ready
    // DECODE | dispatch on opcode
    // EXEC   | ALU operation (OP / OP-IMM)
    // MEM    | load/store access, waits for mem_ready
    // WB     | register writeback, retires
    // BRANCH | conditional PC update, retires
    // JUMP   | link write and jump target, retires
    // HALT   | stopped after ECALL/EBREAK class, start resumes
    // TRAP   | illegal opcode or bus timeout, start resumes at trap vector
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_HALT   = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  instret_q;
    logic              retire, count, waiting, to_hit;
    logic [6:0]        opc;
    logic              rd_nz;
    logic              ir_unused;

    assign opc       = ir[6:0];
    assign rd_nz     = |ir[11:7];
    assign ir_unused = ^ir[31:12];
    assign to_hit    = TO_EN && (to_cnt == TO_LAST);

    assign state      = state_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        count        = 1'b0;
        waiting      = 1'b0;
        busy         = 1'b1;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        trap         = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                case (opc)
                    OPC_OP_IMM, OPC_OP:   state_d = S_EXEC;
                    OPC_LUI, OPC_AUIPC:   state_d = S_WB;
                    OPC_JAL, OPC_JALR:    state_d = S_JUMP;
                    OPC_LOAD, OPC_STORE:  state_d = S_MEM;
                    OPC_BRANCH:           state_d = S_BRANCH;
                    OPC_SYSTEM: begin
                        state_d = S_HALT;
                        count   = 1'b1;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            S_EXEC: begin
                alu_b_sel = (opc == OPC_OP_IMM);
                state_d   = S_WB;
            end
            S_MEM: begin
                alu_b_sel    = 1'b1;
                mem_addr_sel = 1'b1;
                mem_req      = 1'b1;
                mem_we       = (opc == OPC_STORE);
                if (mem_ready) begin
                    if (opc == OPC_STORE) begin
                        retire = 1'b1;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = rd_nz;
                retire = 1'b1;
                // ALU operands stay selected so the unregistered ALU result is still valid here
                case (opc)
                    OPC_LOAD:   wb_sel = 2'd1;
                    OPC_LUI:    wb_sel = 2'd2;
                    OPC_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OPC_OP_IMM: alu_b_sel = 1'b1;
                    default:    wb_sel = 2'd0;
                endcase
            end
            S_BRANCH: begin
                pc_sel = br_taken ? 2'd1 : 2'd0;
                retire = 1'b1;
            end
            S_JUMP: begin
                rf_we  = rd_nz;
                wb_sel = 2'd3;
                retire = 1'b1;
                if (opc == OPC_JALR) begin
                    pc_sel    = 2'd2;
                    alu_b_sel = 1'b1;
                end else begin
                    pc_sel = 2'd1;
                end
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                busy = 1'b0;
                trap = 1'b1;
                if (start) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'd3;
                    cause_d = 2'd0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (retire) begin
            pc_we   = 1'b1;
            count   = 1'b1;
            state_d = halt_req ? S_IDLE : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            to_cnt    <= '0;
            cause_q   <= 2'd0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            to_cnt  <= waiting ? to_cnt + TO_W'(1) : '0;
            if (count) instret_q <= instret_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Directed bench for rv_mc_sequencer (CNT_W=4 so instret wrap is reachable).
module tb_rv_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt_req, mem_ready, br_taken;
    logic [31:0] ir;
    logic        busy, pc_we, ir_we, mdr_we, rf_we, alu_a_sel, alu_b_sel;
    logic        mem_req, mem_we, mem_addr_sel, trap, halted;
    logic [3:0]  state;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [3:0]  instret;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cycles;

    rv_mc_sequencer #(.CNT_W(4), .TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .ir(ir),
        .mem_ready(mem_ready), .br_taken(br_taken), .busy(busy), .state(state),
        .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .trap(trap), .trap_cause(trap_cause), .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from IDLE back to IDLE with ready memory and halt_req set.
    task automatic run_to_idle(input logic [31:0] instr);
        bit done = 1'b0;
        ir = instr; start = 1'b1; mem_ready = 1'b1; halt_req = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (state == 4'd0) done = 1'b1;
        end
        chk("run_to_idle_budget", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        br_taken = 1'b0; ir = 32'h0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_instret", instret, 0);
        rst = 1'b1;

        // ADDI x1,x0,5; halt_req held from the start must only act at retire
        ir = 32'h00500093; mem_ready = 1'b1; halt_req = 1'b1; start = 1'b1;
        tick(); start = 1'b0; #1;
        chk("addi_fetch", state, 1);
        chk("addi_ir_we", ir_we, 1);
        chk("addi_fetch_req", mem_req, 1);
        tick(); chk("addi_decode", state, 2);
        tick(); chk("addi_exec", state, 3);
        chk("addi_exec_bsel", alu_b_sel, 1);
        tick(); chk("addi_wb", state, 5);
        chk("addi_rf_we", rf_we, 1);
        chk("addi_wb_sel", wb_sel, 0);
        chk("addi_pc_we", pc_we, 1);
        tick(); chk("addi_idle", state, 0);
        chk("addi_instret", instret, 1);

        // LW x2,0(x1) with mem_ready delayed 3 cycles
        ir = 32'h0000A103; start = 1'b1;
        tick(); start = 1'b0;
        tick(); mem_ready = 1'b0;
        tick(); #1;
        chk("lw_mem", state, 4);
        chk("lw_addr_sel", mem_addr_sel, 1);
        chk("lw_mem_we", mem_we, 0);
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) req_cycles++;
            chk("lw_no_mdr", mdr_we, 0);
            tick();
        end
        mem_ready = 1'b1; #1;
        if (mem_req) req_cycles++;
        chk("lw_mdr_we", mdr_we, 1);
        chk("lw_req_cycles", req_cycles, 4);
        tick();
        chk("lw_wb", state, 5);
        chk("lw_wb_sel", wb_sel, 1);
        chk("lw_rf_we", rf_we, 1);
        tick(); chk("lw_instret", instret, 2);

        // Illegal opcode trap and restart
        ir = 32'hFFFFFFFF; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("ill_trap", state, 9);
        chk("ill_cause", trap_cause, 1);
        chk("ill_busy", busy, 0);
        chk("ill_trap_o", trap, 1);
        mem_ready = 1'b0; start = 1'b1; #1;
        chk("ill_pc_sel", pc_sel, 3);
        chk("ill_pc_we", pc_we, 1);
        tick(); start = 1'b0;
        chk("ill_refetch", state, 1);
        chk("ill_cause_clr", trap_cause, 0);
        chk("ill_instret", instret, 2);

        // Fetch timeout: 15 waiting cycles then TRAP with cause 2
        for (int i = 0; i < 14; i++) tick();
        chk("to_still_fetch", state, 1);
        tick();
        chk("to_trap", state, 9);
        chk("to_cause", trap_cause, 2);
        chk("to_req_drop", mem_req, 0);

        // Ready on the 15th cycle wins over the timeout
        ir = 32'h00000063; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        mem_ready = 1'b1; #1;
        chk("to_ready_ir_we", ir_we, 1);
        tick(); chk("to_ready_decode", state, 2);
        tick(); chk("beq_branch", state, 6);
        br_taken = 1'b1; #1;
        chk("beq_t_pc_sel", pc_sel, 1);
        chk("beq_t_pc_we", pc_we, 1);
        tick(); chk("beq_t_idle", state, 0);

        // BEQ not taken, halt_req low -> back to FETCH; then JAL x0
        br_taken = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); halt_req = 1'b0; #1;
        chk("beq_nt_pc_sel", pc_sel, 0);
        chk("beq_nt_pc_we", pc_we, 1);
        tick(); chk("beq_nt_fetch", state, 1);
        ir = 32'h0000006F; halt_req = 1'b1;
        tick(); tick();
        chk("jal_jump", state, 7);
        chk("jal_rf_we", rf_we, 0);
        chk("jal_pc_sel", pc_sel, 1);
        chk("jal_wb_sel", wb_sel, 3);
        tick(); chk("jal_instret", instret, 5);

        // JALR x1,0(x1)
        ir = 32'h000080E7; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("jalr_rf_we", rf_we, 1);
        chk("jalr_pc_sel", pc_sel, 2);
        chk("jalr_bsel", alu_b_sel, 1);
        tick(); chk("jalr_instret", instret, 6);

        // ECALL -> HALT counts as retired; start resumes
        ir = 32'h00000073; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("halt_state", state, 8);
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_instret", instret, 7);
        ir = 32'h00112023; start = 1'b1; #1;
        chk("halt_pc_we", pc_we, 1);
        chk("halt_pc_sel", pc_sel, 0);
        tick(); start = 1'b0;
        chk("halt_fetch", state, 1);

        // SW retires straight out of MEM
        tick(); tick();
        chk("sw_mem", state, 4);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_pc_we", pc_we, 1);
        chk("sw_mdr_we", mdr_we, 0);
        tick(); chk("sw_idle", state, 0);
        chk("sw_instret", instret, 8);

        // LUI x5 and AUIPC x0
        ir = 32'h000052B7; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("lui_wb", state, 5);
        chk("lui_wb_sel", wb_sel, 2);
        chk("lui_rf_we", rf_we, 1);
        tick();
        ir = 32'h00000017; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("auipc_rf_we", rf_we, 0);
        chk("auipc_wb_sel", wb_sel, 0);
        chk("auipc_asel", alu_a_sel, 1);
        chk("auipc_bsel", alu_b_sel, 1);
        tick(); chk("auipc_instret", instret, 10);

        // Wrap of the 4-bit counter
        for (int i = 0; i < 5; i++) run_to_idle(32'h00500093);
        chk("wrap_15", instret, 15);
        run_to_idle(32'h00500093);
        chk("wrap_0", instret, 0);

        // Asynchronous reset while waiting in MEM
        ir = 32'h0000A103; start = 1'b1; mem_ready = 1'b1;
        tick(); start = 1'b0;
        tick(); mem_ready = 1'b0;
        tick();
        chk("rstmem_req_before", mem_req, 1);
        rst = 1'b0; #1;
        chk("rstmem_state", state, 0);
        chk("rstmem_req", mem_req, 0);
        chk("rstmem_instret", instret, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
